// File: rtl/stw_test_sequencer.sv
// Stop-the-World self-test initiator: applies four fixed MAC vectors to the systolic array
// and folds the per-PE pass/fail results into a sticky fault map for the repair logic.
module stw_test_sequencer #(
    parameter int unsigned ROWS      = 3,
    parameter int unsigned COLS      = 3,
    parameter int unsigned WORD_SIZE = 16,
    parameter int unsigned TIMEOUT   = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             vector_idx,
    output logic [ROWS*COLS-1:0]   fault_map,
    output logic                   any_fault,
    output logic                   timeout_err,
    output logic                   STW_test_load_en,
    output logic [WORD_SIZE-1:0]   STW_mult_op1,
    output logic [WORD_SIZE-1:0]   STW_mult_op2,
    output logic [WORD_SIZE-1:0]   STW_add_op,
    output logic [WORD_SIZE-1:0]   STW_expected,
    output logic                   STW_start,
    input  logic                   STW_complete,
    input  logic [ROWS*COLS-1:0]   STW_result_mat
);

    localparam int unsigned NumPe = ROWS * COLS;
    localparam int unsigned CntW  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {StIdle, StLoad, StFire, StWait, StAccum, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           idx_q, idx_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic [NumPe-1:0]     fault_map_q, fault_map_d;
    logic                 timeout_err_q, timeout_err_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 load_en_q, load_en_d;
    logic                 fire_q, fire_d;
    logic [WORD_SIZE-1:0] op1_q, op1_d, op2_q, op2_d, add_q, add_d, exp_q, exp_d;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        cnt_d         = cnt_q;
        fault_map_d   = fault_map_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    fault_map_d   = '0;
                    timeout_err_d = 1'b0;
                    idx_d         = 2'd0;
                    state_d       = StLoad;
                end
            end
            StLoad: state_d = StFire;
            StFire: begin
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                if (STW_complete) begin
                    state_d = StAccum;
                end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    fault_map_d   = '1;
                    state_d       = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAccum: begin
                fault_map_d = fault_map_q | ~STW_result_mat;
                if (idx_q == 2'd3) begin
                    state_d = StDone;
                end else begin
                    idx_d   = idx_q + 2'd1;
                    state_d = StLoad;
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are registered from the next state so they line up with state_q.
    always_comb begin
        busy_d    = (state_d != StIdle);
        done_d    = (state_d == StDone);
        load_en_d = (state_d == StLoad);
        fire_d    = (state_d == StFire);
        op1_d     = '0;
        op2_d     = '0;
        add_d     = '0;
        exp_d     = '0;
        if (state_d inside {StLoad, StFire, StWait, StAccum}) begin
            unique case (idx_d)
                2'd0: begin
                    op1_d = WORD_SIZE'(5);
                    op2_d = WORD_SIZE'(7);
                    add_d = WORD_SIZE'(2);
                    exp_d = WORD_SIZE'(37);
                end
                2'd1: ;
                2'd2: begin
                    op1_d = '1;
                    op2_d = WORD_SIZE'(1);
                    exp_d = '1;
                end
                2'd3: begin
                    op1_d = '1;
                    op2_d = '1;
                    add_d = '1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            idx_q         <= 2'd0;
            cnt_q         <= '0;
            fault_map_q   <= '0;
            timeout_err_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            load_en_q     <= 1'b0;
            fire_q        <= 1'b0;
            op1_q         <= '0;
            op2_q         <= '0;
            add_q         <= '0;
            exp_q         <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            cnt_q         <= cnt_d;
            fault_map_q   <= fault_map_d;
            timeout_err_q <= timeout_err_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            load_en_q     <= load_en_d;
            fire_q        <= fire_d;
            op1_q         <= op1_d;
            op2_q         <= op2_d;
            add_q         <= add_d;
            exp_q         <= exp_d;
        end
    end

    assign busy             = busy_q;
    assign done             = done_q;
    assign vector_idx       = idx_q;
    assign fault_map        = fault_map_q;
    assign any_fault        = |fault_map_q;
    assign timeout_err      = timeout_err_q;
    assign STW_test_load_en = load_en_q;
    assign STW_start        = fire_q;
    assign STW_mult_op1     = op1_q;
    assign STW_mult_op2     = op2_q;
    assign STW_add_op       = add_q;
    assign STW_expected     = exp_q;

endmodule

// File: tb/tb_stw_test_sequencer.sv
// Directed bench for stw_test_sequencer with a behavioural STW responder standing in for the array.
module tb_stw_test_sequencer;

    localparam int unsigned ROWS = 3;
    localparam int unsigned COLS = 3;
    localparam int unsigned WS   = 16;
    localparam int unsigned TO   = 64;
    localparam int unsigned N    = ROWS * COLS;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          busy, done, any_fault, timeout_err;
    logic [1:0]    vector_idx;
    logic [N-1:0]  fault_map;
    logic          STW_test_load_en, STW_start;
    logic [WS-1:0] STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected;
    logic          STW_complete = 1'b0;
    logic [N-1:0]  STW_result_mat = '1;

    stw_test_sequencer #(.ROWS(ROWS), .COLS(COLS), .WORD_SIZE(WS), .TIMEOUT(TO)) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .busy             (busy),
        .done             (done),
        .vector_idx       (vector_idx),
        .fault_map        (fault_map),
        .any_fault        (any_fault),
        .timeout_err      (timeout_err),
        .STW_test_load_en (STW_test_load_en),
        .STW_mult_op1     (STW_mult_op1),
        .STW_mult_op2     (STW_mult_op2),
        .STW_add_op       (STW_add_op),
        .STW_expected     (STW_expected),
        .STW_start        (STW_start),
        .STW_complete     (STW_complete),
        .STW_result_mat   (STW_result_mat)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Responder: completes each test W=3 cycles into WAIT with a per-vector result.
    logic         mock_en = 1'b1;
    int           mock_w  = 3;
    logic [N-1:0] mock_res [4];

    initial begin
        forever begin
            @(negedge clk);
            if (mock_en && STW_start) begin
                @(posedge clk);
                #1;
                if (mock_w > 0) begin
                    STW_complete = 1'b0;
                    repeat (mock_w) @(posedge clk);
                    #1;
                end
                STW_result_mat = mock_res[vector_idx];
                STW_complete   = 1'b1;
            end
        end
    end

    // Monitor: counts pulses and captures the operand tuple on every LOAD.
    int           load_cnt = 0, fire_cnt = 0, done_cnt = 0;
    logic [WS-1:0] rec [4][4];

    always @(negedge clk) begin
        if (STW_test_load_en) begin
            if (load_cnt < 4) begin
                rec[load_cnt][0] = STW_mult_op1;
                rec[load_cnt][1] = STW_mult_op2;
                rec[load_cnt][2] = STW_add_op;
                rec[load_cnt][3] = STW_expected;
            end
            load_cnt++;
        end
        if (STW_start) fire_cnt++;
        if (done) done_cnt++;
    end

    // Starts a run from IDLE and returns at the negedge of the DONE cycle; cyc counts from LOAD=1.
    task automatic run_and_wait(input int budget, input bit poke_wait, input bit chk_clear,
                                output int cyc);
        @(negedge clk);
        load_cnt = 0;
        fire_cnt = 0;
        done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        if (chk_clear) begin
            check_eq("clear_fault_map", fault_map, 0);
            check_eq("clear_timeout_err", timeout_err, 0);
        end
        while (!done && cyc < budget) begin
            @(negedge clk);
            cyc++;
            if (poke_wait && cyc == 4) start = 1'b1;
            if (poke_wait && cyc == 5) start = 1'b0;
        end
        check_eq("done_seen", done, 1);
    endtask

    logic [WS-1:0] exp_tbl [4][4];
    int cyc;

    initial begin
        exp_tbl[0] = '{16'd5, 16'd7, 16'd2, 16'd37};
        exp_tbl[1] = '{16'd0, 16'd0, 16'd0, 16'd0};
        exp_tbl[2] = '{16'hFFFF, 16'd1, 16'd0, 16'hFFFF};
        exp_tbl[3] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'd0};
        for (int i = 0; i < 4; i++) mock_res[i] = '1;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_idx", vector_idx, 0);
        check_eq("rst_fault_map", fault_map, 0);
        check_eq("rst_any_fault", any_fault, 0);
        check_eq("rst_timeout", timeout_err, 0);
        check_eq("rst_load_en", STW_test_load_en, 0);
        check_eq("rst_stw_start", STW_start, 0);
        check_eq("rst_ops", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 0);

        // Fault-free run with a stray start during WAIT of v0.
        run_and_wait(200, 1'b1, 1'b0, cyc);
        check_eq("pass_cycles", cyc, 29);
        check_eq("pass_loads", load_cnt, 4);
        check_eq("pass_fires", fire_cnt, 4);
        for (int v = 0; v < 4; v++)
            for (int f = 0; f < 4; f++)
                check_eq($sformatf("op_v%0d_f%0d", v, f), rec[v][f], exp_tbl[v][f]);
        check_eq("pass_fault_map", fault_map, 0);
        check_eq("pass_any_fault", any_fault, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_eq("done_start_ignored", busy, 0);
        check_eq("done_pulse_count", done_cnt, 1);
        check_eq("idle_ops_zero", {STW_mult_op1, STW_add_op}, 0);

        // PE at row 0, col 1 stuck faulty on every vector.
        for (int i = 0; i < 4; i++) mock_res[i] = 9'h1FD;
        run_and_wait(200, 1'b0, 1'b0, cyc);
        check_eq("stuck_fault_map", fault_map, 9'h002);
        check_eq("stuck_any_fault", any_fault, 1);

        // PE 0 fails on v2 only.
        for (int i = 0; i < 4; i++) mock_res[i] = 9'h1FF;
        mock_res[2] = 9'h1FE;
        run_and_wait(200, 1'b0, 1'b0, cyc);
        check_eq("v2_fault_map", fault_map, 9'h001);
        check_eq("v2_any_fault", any_fault, 1);

        // STW_complete held low: v0 times out.
        mock_res[2] = 9'h1FF;
        mock_en = 1'b0;
        STW_complete = 1'b0;
        run_and_wait(200, 1'b0, 1'b0, cyc);
        check_eq("to_cycles", cyc, 3 + TO);
        check_eq("to_timeout_err", timeout_err, 1);
        check_eq("to_fault_map", fault_map, 9'h1FF);
        repeat (4) @(negedge clk);
        check_eq("to_loads", load_cnt, 1);
        check_eq("to_persist_err", timeout_err, 1);
        check_eq("to_persist_map", fault_map, 9'h1FF);
        check_eq("to_persist_any", any_fault, 1);

        // A fresh start clears the sticky results.
        mock_en = 1'b1;
        run_and_wait(200, 1'b0, 1'b1, cyc);
        check_eq("rerun_fault_map", fault_map, 0);

        // Reset during WAIT of v2, then a full rerun from v0.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(vector_idx == 2'd2 && busy && !STW_test_load_en && !STW_start) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("reached_v2_wait", vector_idx, 2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("mid_rst_busy", busy, 0);
        check_eq("mid_rst_idx", vector_idx, 0);
        check_eq("mid_rst_strobes", {STW_test_load_en, STW_start, done}, 0);
        check_eq("mid_rst_ops", {STW_mult_op1, STW_mult_op2, STW_add_op, STW_expected}, 0);
        check_eq("mid_rst_flags", {fault_map, any_fault, timeout_err}, 0);
        repeat (6) @(negedge clk);
        run_and_wait(200, 1'b0, 1'b0, cyc);
        check_eq("post_rst_cycles", cyc, 29);
        check_eq("post_rst_loads", load_cnt, 4);
        check_eq("post_rst_v0_op1", rec[0][0], exp_tbl[0][0]);
        check_eq("post_rst_fault_map", fault_map, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/stw_test_sequencer.md
# stw_test_sequencer

Initiator for the Stop-the-World (STW) self-test port of `traditional_systolic_stw`. It replaces bench-driven STW stimulus. On a start request it loads a fixed set of four MAC test vectors into the array one at a time, fires each test, and waits for `STW_complete`. It accumulates the per-PE pass/fail results into a sticky fault map for the BISR repair logic downstream.

## Interface
- `ROWS`, default 3: systolic array rows.
- `COLS`, default 3: systolic array columns.
- `WORD_SIZE`, default 16: operand/result width.
- `TIMEOUT`, default 64: maximum cycles spent in WAIT per vector.

- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `start`  in  1  request a full test run; accepted only in IDLE.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when a run finishes (pass, fail or timeout).
- `vector_idx`  out  2  index of the vector currently being applied.
- `fault_map`  out  ROWS*COLS  1 = PE faulty; bit index `r*COLS+c`; sticky until the next accepted start.
- `any_fault`  out  1  OR-reduction of `fault_map`.
- `timeout_err`  out  1  sticky; set if any vector times out.
- `STW_test_load_en`  out  1  to array; loads op/expected registers.
- `STW_mult_op1`, `STW_mult_op2`, `STW_add_op`, `STW_expected`  out  WORD_SIZE each  to array; test operands and golden result.
- `STW_start`  out  1  to array; one-cycle test launch.
- `STW_complete`  in  1  from array; test finished (level).
- `STW_result_mat`  in  ROWS*COLS  from array; 1 = PE passed, 0 = PE failed.

## Operation
- Vector table (A = all-ones in WORD_SIZE; results are mod 2^WORD_SIZE):
  - v0: op1=5, op2=7, add=2, exp=37.
  - v1: op1=0, op2=0, add=0, exp=0.
  - v2: op1=A, op2=1, add=0, exp=A.
  - v3: op1=A, op2=A, add=A, exp=0.
- FSM states:
  - IDLE: if `start`, clear `fault_map`, `timeout_err` and the vector index, then go to LOAD.
  - LOAD: `STW_test_load_en`=1 for exactly one cycle, then go to FIRE.
  - FIRE: `STW_start`=1 for exactly one cycle, clear the wait counter, then go to WAIT.
  - WAIT: if `STW_complete`=1, go to ACCUM. Otherwise, if the wait counter reaches TIMEOUT-1, set `timeout_err`, set `fault_map` to all ones, and go to DONE. Otherwise increment the counter.
  - ACCUM: `fault_map |= ~STW_result_mat`. If the vector index is 3, go to DONE; otherwise increment the index and go to LOAD.
  - DONE: `done`=1 for one cycle, then go to IDLE.
- Operand outputs hold the current vector's values from LOAD through ACCUM. They drive 0 in IDLE and DONE.
- `STW_complete` is sampled only in WAIT. A value left high from a previous test is ignored in LOAD and FIRE.
- `start` is ignored in every state except IDLE, including DONE.
- `fault_map`, `any_fault` and `timeout_err` persist through IDLE until the next accepted start.

## Timing
- Reset values: all outputs 0, state IDLE, `vector_idx`=0.
- Reset mid-run returns to IDLE within one edge and discards partial results. The array sees `STW_start`/`STW_test_load_en` drop the same cycle.
- Let accepting `start` at edge 0 be the reference. Then:
  - LOAD occupies cycle 1 and FIRE occupies cycle 2.
  - WAIT begins at cycle 3.
  - If `STW_complete` is high at the edge W cycles into WAIT, ACCUM follows.
- Per-vector cost is 4+W cycles (LOAD, FIRE, WAIT×(W+1), ACCUM, with W ≥ 0). A full run is 1 + 4×(4+W) + 1 cycles including DONE.
- A `fault_map` update is visible the cycle after ACCUM. `any_fault` is combinational from `fault_map`.
- `done` and the final `fault_map` are valid in the same cycle.

## Test plan
- Fault-free array (all PEs pass each vector; complete after 3 WAIT cycles):
  - LOAD/FIRE pulses occur exactly 4 times, with op tuples matching v0–v3.
  - `done` pulses once; `fault_map`=9'b0 and `any_fault`=0.
- Stuck fault injected at col 1, row 0 via `fault_inject_bus`: `fault_map` bit 1 is set and all others are clear; `any_fault`=1.
- Responder mock returns `STW_result_mat`=9'h1FE on v2 only: final `fault_map`=9'h001, and the bit persists through v3.
- `STW_complete` held low:
  - After TIMEOUT WAIT cycles on v0, `timeout_err`=1 and `fault_map`=9'h1FF.
  - `done` pulses, and no v1 LOAD occurs.
- `start` pulsed during WAIT and during DONE: both ignored. A new start in IDLE clears the prior `fault_map` and `timeout_err`.
- `rst` asserted during WAIT of v2: all outputs are 0 next cycle. A following start runs the full four vectors from v0.
